// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the debounce / edge-detect block.
//   - deb_state_t : FSM state encoding (STABLE, CHECK)
//   - cnt_width() : width of the qualification counter for a given
//                   STABLE_CYCLES value, usable in localparam context
// ---------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } deb_state_t;

    // Wide enough to hold any value 0..stable_cycles.
    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage : debounce_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk    in   1  clock, posedge
//     reset  in   1  synchronous, active-low reset (q -> 0)
//     inc    in   1  increment request; ignored once q is all-ones
//     clr    in   1  synchronous clear; wins over inc
//     q      out  W  current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : sat_counter

// File: rtl/debounce_edge_detect.sv
// ---------------------------------------------------------------------------
// debounce_edge_detect
//   Debounces a single already-synchronous bit. A change on din is accepted
//   only after STABLE_CYCLES consecutive samples that differ from the current
//   level; a candidate that collapses earlier is counted as a glitch.
//   Ports:
//     clk         in   1         clock, posedge
//     reset       in   1         synchronous, active-low reset
//     din         in   1         registered input bit
//     clr_glitch  in   1         synchronous clear of glitch_cnt
//     level       out  1         debounced level
//     rise        out  1         one-cycle pulse after an accepted 0->1
//     fall        out  1         one-cycle pulse after an accepted 1->0
//     busy        out  1         high while a candidate is being qualified
//     glitch_cnt  out  GLITCH_W  saturating count of rejected candidates
//   All outputs come straight from flops.
// ---------------------------------------------------------------------------
module debounce_edge_detect
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_LEVEL   = 1'b0,
    parameter int   GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                din,
    input  logic                clr_glitch,
    output logic                level,
    output logic                rise,
    output logic                fall,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    // cnt_q + 1 == STABLE_CYCLES is the same test as cnt_q == STABLE_CYCLES-1,
    // which avoids widening the adder just for the compare.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             busy_q,  busy_d;
    logic             accept;
    logic             glitch_inc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        accept     = 1'b0;
        glitch_inc = 1'b0;

        case (state_q)
            ST_STABLE: begin
                if (din != level_q) begin
                    if (STABLE_CYCLES == 1) begin
                        // A single differing sample is already enough.
                        accept = 1'b1;
                    end else begin
                        state_d = ST_CHECK;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (din != level_q) begin
                    if (cnt_q == CNT_LAST) begin
                        accept  = 1'b1;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Input fell back before qualifying: drop the candidate.
                    glitch_inc = 1'b1;
                    state_d    = ST_STABLE;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            level_d = ~level_q;
        end
        // The pulse direction is the new level, so it is set in the same
        // edge as level and shows up during the following cycle.
        rise_d = accept & ~level_q;
        fall_d = accept &  level_q;
        busy_d = (state_d == ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Reset also clears the glitch counter, so a candidate discarded by
    // reset is never counted even if it coincides with a reject.
    sat_counter #(
        .W (GLITCH_W)
    ) u_glitch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (glitch_inc),
        .clr   (clr_glitch),
        .q     (glitch_cnt)
    );

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign busy  = busy_q;

endmodule : debounce_edge_detect
